// File: rtl/usb_rx_bit_timer.sv
// rtl/usb_rx_bit_timer.sv - USB RX bit timing, NRZI destuffing and byte framing
//
// Purpose:
//   Tracks the bit-period phase of the incoming USB line and realigns it on
//   every line transition. It samples once per bit at SAMPLE_PHASE. Data bits
//   produce a one-cycle shift strobe for the downstream RX shift register.
//   A bit that follows STUFF_RUN consecutive decoded ones is a stuff bit: it
//   is dropped, and a 1 in that position is reported as a stuff error. The
//   block also counts shifted bits and pulses once per completed byte.
//
// Ports:
//   i_clk             system clock, rising edge
//   i_rst             synchronous active-high reset, highest priority
//   i_enable_timer    high while a packet is received; low idles the block
//   i_d_edge          one-cycle pulse on any differential line transition
//   i_d_decoded       NRZI-decoded bit, valid in the sample cycle
//   o_shift_enable    one-cycle strobe: shift i_d_decoded into the RX register
//   o_byte_received   one-cycle pulse, one cycle after the byte-completing shift
//   o_stuff_err       one-cycle pulse: the stuff position carried a 1
//   o_bit_count       data bits shifted so far in the current byte

module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_PHASE  = 3,
    parameter int BITS_PER_BYTE = 8,
    parameter int STUFF_RUN     = 6,
    localparam int BCW          = $clog2(BITS_PER_BYTE) + 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_enable_timer,
    input  logic           i_d_edge,
    input  logic           i_d_decoded,
    output logic           o_shift_enable,
    output logic           o_byte_received,
    output logic           o_stuff_err,
    output logic [BCW-1:0] o_bit_count
);

    localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_RUN + 1);

    localparam logic [PW-1:0]  PH_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0]  PH_SAMPLE = PW'(SAMPLE_PHASE);
    localparam logic [PW-1:0]  PH_ONE    = PW'(1);
    localparam logic [OW-1:0]  RUN_MAX   = OW'(STUFF_RUN);
    localparam logic [OW-1:0]  RUN_ONE   = OW'(1);
    localparam logic [BCW-1:0] BC_LAST   = BCW'(BITS_PER_BYTE - 1);
    localparam logic [BCW-1:0] BC_ONE    = BCW'(1);

    logic [PW-1:0]  r_phase;
    logic [OW-1:0]  r_ones_run;
    logic [BCW-1:0] r_bit_count;
    logic           r_shift_enable;
    logic           r_shift_wrap;
    logic           r_byte_received;
    logic           r_stuff_err;

    logic           w_sample;
    logic           w_stuff_pos;
    logic           w_bit_wrap;
    logic [PW-1:0]  w_phase_next;

    assign w_sample    = i_enable_timer && (r_phase == PH_SAMPLE);
    assign w_stuff_pos = (r_ones_run == RUN_MAX);
    assign w_bit_wrap  = (r_bit_count == BC_LAST);

    // An edge cycle counts as phase 0, so the following cycle is phase 1.
    // A sample coinciding with an edge still uses the pre-edge phase.
    always_comb begin
        w_phase_next = '0;
        if (i_d_edge) begin
            w_phase_next = PH_ONE;
        end else if (r_phase != PH_LAST) begin
            w_phase_next = r_phase + PH_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable_timer) begin
            r_phase         <= '0;
            r_ones_run      <= '0;
            r_bit_count     <= '0;
            r_shift_enable  <= 1'b0;
            r_shift_wrap    <= 1'b0;
            r_byte_received <= 1'b0;
            r_stuff_err     <= 1'b0;
        end else begin
            r_phase         <= w_phase_next;
            r_shift_enable  <= 1'b0;
            r_stuff_err     <= 1'b0;
            // Byte pulse lags the completing shift by one cycle so the
            // shift register has absorbed the last bit.
            r_byte_received <= r_shift_enable && r_shift_wrap;
            if (w_sample) begin
                if (!w_stuff_pos) begin
                    r_shift_enable <= 1'b1;
                    r_shift_wrap   <= w_bit_wrap;
                    r_ones_run     <= i_d_decoded ? (r_ones_run + RUN_ONE) : '0;
                    r_bit_count    <= w_bit_wrap ? '0 : (r_bit_count + BC_ONE);
                end else begin
                    // Stuff bit: dropped; run restarts whatever its value.
                    r_ones_run  <= '0;
                    r_stuff_err <= i_d_decoded;
                end
            end
        end
    end

    // Gating by enable hides a strobe registered in the last enabled cycle,
    // so nothing leaks out in the first disabled cycle.
    assign o_shift_enable  = r_shift_enable  && i_enable_timer;
    assign o_byte_received = r_byte_received && i_enable_timer;
    assign o_stuff_err     = r_stuff_err     && i_enable_timer;
    assign o_bit_count     = i_enable_timer ? r_bit_count : '0;

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// tb/tb_usb_rx_bit_timer.sv - directed self-checking bench for usb_rx_bit_timer

module tb_usb_rx_bit_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       de  = 1'b0;
    logic       dd  = 1'b0;
    logic       shift_en;
    logic       byte_rx;
    logic       stuff_err;
    logic [3:0] bit_count;

    int n_cmp = 0;
    int n_err = 0;

    int exp_sh[$];
    int exp_st[$];
    int exp_by[$];
    int clears[$];

    usb_rx_bit_timer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_enable_timer  (en),
        .i_d_edge        (de),
        .i_d_decoded     (dd),
        .o_shift_enable  (shift_en),
        .o_byte_received (byte_rx),
        .o_stuff_err     (stuff_err),
        .o_bit_count     (bit_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic d_e, input logic d_d);
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        de  = d_e;
        dd  = d_d;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int c, input logic [6:0] got, input logic [6:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s cyc %0d: got sh/by/se/bc=%b want %b", tag, c, got, want);
        end
    endtask

    task automatic run_test(input string name, input int ncyc, input int edge_c, input int rst_c,
                            input int off_lo1, input int off_hi1, input int off_lo2, input int off_hi2,
                            input int dd_lo1, input int dd_hi1, input int dd_lo2, input int dd_hi2);
        logic       e_sh, e_by, e_se;
        int         clr, cnt;
        logic [3:0] e_bc;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            check({name, "_reset"}, k, {shift_en, byte_rx, stuff_err, bit_count}, 7'd0);
        end
        for (int c = 0; c < ncyc; c++) begin
            step(c == rst_c,
                 !((c >= off_lo1 && c < off_hi1) || (c >= off_lo2 && c < off_hi2)),
                 c == edge_c,
                 (c >= dd_lo1 && c < dd_hi1) || (c >= dd_lo2 && c < dd_hi2));
            e_sh = 1'b0;
            e_by = 1'b0;
            e_se = 1'b0;
            foreach (exp_sh[i]) if (exp_sh[i] == c) e_sh = 1'b1;
            foreach (exp_by[i]) if (exp_by[i] == c) e_by = 1'b1;
            foreach (exp_st[i]) if (exp_st[i] == c) e_se = 1'b1;
            clr = -1;
            foreach (clears[i]) if (clears[i] <= c) clr = clears[i];
            cnt = 0;
            foreach (exp_sh[i]) if (exp_sh[i] <= c && exp_sh[i] >= clr) cnt++;
            e_bc = 4'(cnt % 8);
            check(name, c, {shift_en, byte_rx, stuff_err, bit_count}, {e_sh, e_by, e_se, e_bc});
        end
    endtask

    initial begin
        // 1: free-running, all zeros, one full byte
        exp_sh = {};
        for (int k = 0; k < 8; k++) exp_sh.push_back(4 + 8 * k);
        exp_by = '{61};
        exp_st = {};
        clears = {};
        run_test("plain", 64, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1);

        // 2: edge at cycle 6 pulls the next sample in from 11 to 9
        exp_sh = '{4, 10, 18, 26, 34, 42, 50, 58};
        exp_by = '{59};
        run_test("resync", 64, 6, -1, -1, -1, -1, -1, -1, -1, -1, -1);

        // 7: edge in the sample cycle still samples, then realigns
        exp_sh = '{4, 7, 15, 23, 31, 39, 47, 55};
        exp_by = '{56};
        run_test("edge_on_sample", 60, 3, -1, -1, -1, -1, -1, -1, -1, -1, -1);

        // 3: six ones then a 0 stuff bit: dropped silently
        exp_sh = '{4, 12, 20, 28, 36, 44, 60};
        exp_by = {};
        run_test("stuff_ok", 64, -1, -1, -1, -1, -1, -1, 0, 48, -1, -1);

        // 4: stuff position carries a 1, run restarts, second violation later
        exp_sh = '{4, 12, 20, 28, 36, 44, 60, 68, 76, 84, 92, 100, 108};
        exp_st = '{52, 116};
        exp_by = '{69};
        run_test("stuff_err", 121, -1, -1, -1, -1, -1, -1, 0, 56, 64, 200);

        // 5: run of ones carried across a byte boundary
        exp_sh = '{4, 12, 20, 28, 36, 44, 52, 60, 68, 84};
        exp_st = {};
        exp_by = '{61};
        run_test("cross_byte", 90, -1, -1, -1, -1, -1, -1, 24, 72, -1, -1);

        // 6a: enable dropped mid-byte, then dropped right after a sample
        exp_sh = '{4, 12, 20, 44, 52};
        exp_by = {};
        clears = '{27, 36};
        run_test("disable", 56, -1, -1, 27, 32, 36, 40, -1, -1, -1, -1);

        // 6b: rst pulsed mid-byte while enabled
        exp_sh = '{4, 12, 20, 27, 35, 43};
        clears = '{23};
        run_test("mid_rst", 46, -1, 22, -1, -1, -1, -1, -1, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
